// File: rtl/mem_pkg.sv
// Shared widths, word type and address split helpers
// for the register-based RAM hierarchy.
package mem_pkg;
  localparam int DATA_W = 16;
  localparam int BANK_W = 3;
  localparam int LOCAL_W = 6;
  localparam int ADDR_W = BANK_W + LOCAL_W;
  localparam int NBANKS = 1 << BANK_W;
  localparam int BANK_DEPTH = 1 << LOCAL_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [BANK_W-1:0] bank_t;
  typedef logic [LOCAL_W-1:0] laddr_t;

  function automatic bank_t bank_of(addr_t a);
    return a[ADDR_W-1:LOCAL_W];
  endfunction

  function automatic laddr_t local_of(addr_t a);
    return a[LOCAL_W-1:0];
  endfunction
endpackage

// File: rtl/ram_512_if.sv
// Access bus for ram_512: write enable, address,
// write data and combinational read data.
interface ram_512_if;
  import mem_pkg::*;
  logic  load;
  addr_t address;
  word_t in;
  word_t out;

  modport master (
    output load,
    output address,
    output in,
    input  out
  );

  modport slave (
    input  load,
    input  address,
    input  in,
    output out
  );
endinterface

// File: rtl/ram_64.sv
// 64 x DATA_W register bank, async clear,
// synchronous write, combinational read.
module ram_64
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  laddr_t address,
  input  word_t  in,
  output word_t  out
);
  word_t mem_q [BANK_DEPTH];

  // Clear every word on reset, else write the addressed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BANK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (load) begin
      mem_q[address] <= in;
    end
  end

  assign out = mem_q[address];
endmodule

// File: rtl/ram_512.sv
// 512 x DATA_W memory: eight ram_64 banks with
// a load demux on the bank bits and an 8:1 read mux.
module ram_512
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  ram_512_if.slave bus
);
  bank_t  bank_sel;
  laddr_t local_addr;
  logic  [NBANKS-1:0] bank_load;
  word_t bank_out [NBANKS];

  assign bank_sel   = bank_of(bus.address);
  assign local_addr = local_of(bus.address);

  // Steer load to the single selected bank
  always_comb begin
    bank_load = '0;
    bank_load[bank_sel] = bus.load;
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    ram_64 u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (bank_load[b]),
      .address (local_addr),
      .in      (bus.in),
      .out     (bank_out[b])
    );
  end

  assign bus.out = bank_out[bank_sel];
endmodule

// File: tb/tb_ram_512.sv
// Directed self-checking bench for ram_512.
// Expected values are hand-computed constants.
module tb_ram_512;
  import mem_pkg::*;

  logic clk;
  logic rst_n;
  int checks;
  int errors;

  ram_512_if bus ();

  ram_512 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input word_t exp);
    checks++;
    assert (bus.out === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, bus.out, exp);
    end
  endtask

  task automatic rd(input string tag, input addr_t a,
                    input word_t exp);
    bus.address = a;
    #1;
    chk(tag, exp);
  endtask

  task automatic wr(input addr_t a, input word_t d);
    @(negedge clk);
    bus.address = a;
    bus.in = d;
    bus.load = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.load = 1'b0;
    bus.address = '0;
    bus.in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    rd("rst_a0", 9'd0, 16'h0000);
    rd("rst_a1", 9'd1, 16'h0000);
    rd("rst_a8", 9'd8, 16'h0000);
    rd("rst_a256", 9'd256, 16'h0000);
    rd("rst_a511", 9'd511, 16'h0000);

    wr(9'd1, 16'h00FF);
    wr(9'd8, 16'hF0F0);
    wr(9'd256, 16'hAAAA);
    @(negedge clk);
    rd("wr_a1", 9'd1, 16'h00FF);
    rd("wr_a8", 9'd8, 16'hF0F0);
    rd("wr_a256", 9'd256, 16'hAAAA);
    rd("wr_a0", 9'd0, 16'h0000);

    wr(9'd0, 16'h1234);
    wr(9'd64, 16'h5678);
    @(negedge clk);
    rd("iso_a0", 9'd0, 16'h1234);
    rd("iso_a64", 9'd64, 16'h5678);
    rd("iso_a128", 9'd128, 16'h0000);
    rd("iso_a1", 9'd1, 16'h00FF);

    @(negedge clk);
    bus.address = 9'd1;
    bus.in = 16'hFFFF;
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_a1", 16'h00FF);
    end

    @(negedge clk);
    bus.address = 9'd511;
    bus.in = 16'hBEEF;
    bus.load = 1'b1;
    #1;
    chk("rdw_before", 16'h0000);
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    chk("rdw_after", 16'hBEEF);

    @(negedge clk);
    rd("pre_rst_a1", 9'd1, 16'h00FF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_drop", 16'h0000);
    bus.address = 9'd300;
    bus.in = 16'h7777;
    bus.load = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_blocks_wr", 16'h0000);
    @(negedge clk);
    bus.load = 1'b0;
    rst_n = 1'b1;
    rd("post_a300", 9'd300, 16'h0000);
    rd("post_a1", 9'd1, 16'h0000);
    rd("post_a8", 9'd8, 16'h0000);
    rd("post_a256", 9'd256, 16'h0000);
    rd("post_a511", 9'd511, 16'h0000);
    rd("post_a64", 9'd64, 16'h0000);

    wr(9'd5, 16'h0505);
    rd("first_wr", 9'd5, 16'h0505);
    rd("first_wr_a4", 9'd4, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
